// File: rtl/layer_2_channel_packer.sv
// ---------------------------------------------------------------------------
// layer_2_channel_packer
//
// Producer-side front end for the layer-2 feature-map blocks. A serial
// stream of fp32 channel words (one per beat) is gathered into pixel words
// of NUM_CH lanes. Each completed pixel is broadcast onto the shared
// data_in/valid_in bus of the feature maps with a one-cycle valid strobe,
// tagged with its row/column inside an IMG_SIZE x IMG_SIZE frame.
//
// Ports
//   Clk          clock
//   Rst          synchronous active-high reset
//   start        begin one frame (only looked at while idle)
//   s_data       incoming channel word
//   s_valid      s_data is valid
//   s_last       producer's marker for the final word of the frame
//   s_ready      a word is accepted this cycle when s_valid is also high
//   m_data       packed pixel, channel k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   m_valid      one-cycle strobe, m_data holds a new pixel
//   m_row/m_col  position of the pixel currently on m_data
//   busy         a frame is in progress
//   frame_done   one-cycle pulse together with the final pixel's m_valid
//   err_framing  sticky flag: s_last did not line up with the frame end
// ---------------------------------------------------------------------------
module layer_2_channel_packer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 16,
    parameter  int IMG_SIZE   = 208,
    localparam int CW         = $clog2(IMG_SIZE)
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         start,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
    output logic                         m_valid,
    output logic [CW-1:0]                m_row,
    output logic [CW-1:0]                m_col,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_framing
);

    localparam int             CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CH - 1);
    localparam logic [CW-1:0]  LAST_POS = CW'(IMG_SIZE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } state_t;

    state_t                         state;
    state_t                         state_next;

    logic [CHW-1:0]                 ch_cnt;
    logic [CW-1:0]                  row;
    logic [CW-1:0]                  col;
    logic [DATA_WIDTH-1:0]          shadow [NUM_CH];
    logic [NUM_CH*DATA_WIDTH-1:0]   pixel_word;

    logic                           beat_accept;
    logic                           pixel_complete;
    logic                           last_pixel_pos;
    logic                           at_final_beat;
    logic                           frame_end;
    logic                           frame_start;
    logic                           framing_bad;

    // Beat / pixel / frame qualifiers shared by the FSM and the datapath.
    // at_final_beat describes the counter position only; it is combined with
    // beat_accept wherever an actual word is involved.
    always_comb begin
        beat_accept    = (state == PACK) && s_valid;
        last_pixel_pos = (row == LAST_POS) && (col == LAST_POS);
        at_final_beat  = (ch_cnt == LAST_CH) && last_pixel_pos;
        pixel_complete = beat_accept && (ch_cnt == LAST_CH);
        frame_end      = pixel_complete && last_pixel_pos;
        frame_start    = (state == IDLE) && start;
        framing_bad    = beat_accept && (s_last != at_final_beat);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded handshake outputs. The frame
    // ends on the same edge that launches the last pixel, so s_ready is
    // already low while that pixel's m_valid is on the bus.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = PACK;
                end
            end
            PACK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (frame_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Channel, column and row counters. They only move on accepted beats,
    // so s_valid gaps freeze the whole position. A new start re-zeroes
    // them, which also throws away any partial pixel left by a reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ch_cnt <= '0;
            row    <= '0;
            col    <= '0;
        end else if (frame_start) begin
            ch_cnt <= '0;
            row    <= '0;
            col    <= '0;
        end else if (beat_accept) begin
            if (ch_cnt == LAST_CH) begin
                ch_cnt <= '0;
            end else begin
                ch_cnt <= ch_cnt + 1'b1;
            end
            if (pixel_complete) begin
                if (col == LAST_POS) begin
                    col <= '0;
                    if (row == LAST_POS) begin
                        row <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Shadow lanes collecting the channels of the pixel being assembled.
    // Stale contents never leak out because every lane is rewritten before
    // the pixel completes, so no reset is needed here.
    always_ff @(posedge Clk) begin
        if (beat_accept) begin
            shadow[ch_cnt] <= s_data;
        end
    end

    // The top lane is taken straight from the incoming beat so the pixel
    // can be launched on the edge that accepts its last channel, giving a
    // single cycle from the final beat to m_valid.
    always_comb begin
        pixel_word = '0;
        for (int k = 0; k < NUM_CH - 1; k++) begin
            pixel_word[k*DATA_WIDTH +: DATA_WIDTH] = shadow[k];
        end
        pixel_word[(NUM_CH-1)*DATA_WIDTH +: DATA_WIDTH] = s_data;
    end

    // Output register towards the feature-map bus. There is no backpressure,
    // so m_valid is a plain strobe and m_data/m_row/m_col simply hold
    // between pixels.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_row      <= '0;
            m_col      <= '0;
            frame_done <= 1'b0;
        end else begin
            m_valid    <= pixel_complete;
            frame_done <= frame_end;
            if (pixel_complete) begin
                m_data <= pixel_word;
                m_row  <= row;
                m_col  <= col;
            end
        end
    end

    // Sticky framing error: s_last seen early, or missing on the final beat.
    // Counting is not affected; the frame length is fixed by the counters.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_framing <= 1'b0;
        end else if (frame_start) begin
            err_framing <= 1'b0;
        end else if (framing_bad) begin
            err_framing <= 1'b1;
        end
    end

endmodule

// File: tb/tb_layer_2_channel_packer.sv
// ---------------------------------------------------------------------------
// tb_layer_2_channel_packer
//
// Drives the packer with a 4x4 frame (256 beats) under several gap / s_last
// patterns taken from a scenario table, plus hand-written reset and idle
// sequences. A frame-level reference model predicts every cycle's outputs.
// ---------------------------------------------------------------------------
module tb_layer_2_channel_packer;

    localparam int DW    = 32;
    localparam int NCH   = 16;
    localparam int IMG   = 4;
    localparam int CWTB  = $clog2(IMG);
    localparam int TOTAL = IMG * IMG * NCH;

    logic                  Clk;
    logic                  Rst;
    logic                  start;
    logic [DW-1:0]         s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [NCH*DW-1:0]     m_data;
    logic                  m_valid;
    logic [CWTB-1:0]       m_row;
    logic [CWTB-1:0]       m_col;
    logic                  busy;
    logic                  frame_done;
    logic                  err_framing;

    layer_2_channel_packer #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .IMG_SIZE   (IMG)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .start       (start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_row       (m_row),
        .m_col       (m_col),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_framing (err_framing)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // One frame scenario: input pattern and what the frame must produce.
    typedef struct {
        int duty;            // percent of cycles with s_valid high
        int extra_last_beat; // beat index carrying a stray s_last, -1 = none
        bit drop_final_last; // leave s_last low on the final beat
        bit index_data;      // s_data = beat index instead of random
        int exp_pixels;
        int exp_done;
        bit exp_err;
    } scen_t;

    scen_t scen [5];

    // Reference model: frame-level view of what the packer must do.
    bit                 md_pack;
    int                 md_beats;
    bit                 md_err;
    logic [DW-1:0]      md_pix [NCH];
    logic [NCH*DW-1:0]  ex_data;
    logic [CWTB-1:0]    ex_row;
    logic [CWTB-1:0]    ex_col;
    bit                 ex_valid;
    bit                 ex_done;

    int n_checks;
    int n_fail;
    int obs_pix;
    int obs_done;

    task automatic chk(input string name, input logic [NCH*DW-1:0] act,
                       input logic [NCH*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and advance the model to the state the DUT
    // should show after the coming clock edge.
    task automatic applyStimulus(input bit rst, input bit st, input bit vld,
                                 input logic [DW-1:0] dat, input bit lst);
        int  lane;
        int  pix;
        bit  fin;
        Rst     = rst;
        start   = st;
        s_valid = vld;
        s_data  = dat;
        s_last  = lst;
        ex_valid = 1'b0;
        ex_done  = 1'b0;
        if (rst) begin
            md_pack  = 1'b0;
            md_beats = 0;
            md_err   = 1'b0;
            ex_data  = '0;
            ex_row   = '0;
            ex_col   = '0;
        end else if (!md_pack) begin
            if (st) begin
                md_pack  = 1'b1;
                md_beats = 0;
                md_err   = 1'b0;
            end
        end else if (vld) begin
            lane = md_beats % NCH;
            pix  = md_beats / NCH;
            fin  = (md_beats == TOTAL - 1);
            md_pix[lane] = dat;
            if (lst != fin) md_err = 1'b1;
            if (lane == NCH - 1) begin
                ex_valid = 1'b1;
                for (int k = 0; k < NCH; k++) ex_data[k*DW +: DW] = md_pix[k];
                ex_row = CWTB'(pix / IMG);
                ex_col = CWTB'(pix % IMG);
                if (fin) begin
                    ex_done = 1'b1;
                    md_pack = 1'b0;
                end
            end
            md_beats++;
        end
    endtask

    task automatic checkOutput();
        chk("s_ready",     (NCH*DW)'(s_ready),     (NCH*DW)'(md_pack));
        chk("busy",        (NCH*DW)'(busy),        (NCH*DW)'(md_pack));
        chk("m_valid",     (NCH*DW)'(m_valid),     (NCH*DW)'(ex_valid));
        chk("frame_done",  (NCH*DW)'(frame_done),  (NCH*DW)'(ex_done));
        chk("err_framing", (NCH*DW)'(err_framing), (NCH*DW)'(md_err));
        chk("m_data",      m_data,                 ex_data);
        chk("m_row",       (NCH*DW)'(m_row),       (NCH*DW)'(ex_row));
        chk("m_col",       (NCH*DW)'(m_col),       (NCH*DW)'(ex_col));
        if (m_valid === 1'b1) obs_pix++;
        if (frame_done === 1'b1) obs_done++;
    endtask

    task automatic cycle(input bit rst, input bit st, input bit vld,
                         input logic [DW-1:0] dat, input bit lst);
        applyStimulus(rst, st, vld, dat, lst);
        @(negedge Clk);
        checkOutput();
    endtask

    task automatic runFrame(input int id, input scen_t sc);
        int            guard;
        int            b;
        bit            vld;
        bit            lst;
        logic [DW-1:0] dat;
        obs_pix  = 0;
        obs_done = 0;
        cycle(1'b0, 1'b1, 1'b0, $urandom, 1'b0);
        guard = 0;
        while (md_pack && guard < 4000) begin
            b   = md_beats;
            vld = (int'($urandom_range(99)) < sc.duty);
            if (vld) begin
                dat = sc.index_data ? DW'(b) : DW'($urandom);
                lst = (b == TOTAL - 1) ? !sc.drop_final_last
                                       : (b == sc.extra_last_beat);
            end else begin
                dat = DW'($urandom);
                lst = 1'($urandom);
            end
            cycle(1'b0, 1'($urandom), vld, dat, lst);
            guard++;
        end
        if (md_pack) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL frame %0d timeout: got %0d beats expected %0d",
                     id, md_beats, TOTAL);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
        chk($sformatf("frame %0d pixel count", id), (NCH*DW)'(obs_pix),
            (NCH*DW)'(sc.exp_pixels));
        chk($sformatf("frame %0d frame_done count", id), (NCH*DW)'(obs_done),
            (NCH*DW)'(sc.exp_done));
        chk($sformatf("frame %0d err_framing", id), (NCH*DW)'(err_framing),
            (NCH*DW)'(sc.exp_err));
        chk($sformatf("frame %0d s_ready after", id), (NCH*DW)'(s_ready),
            (NCH*DW)'(0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        obs_pix  = 0;
        obs_done = 0;
        md_pack  = 1'b0;
        md_beats = 0;
        md_err   = 1'b0;
        ex_data  = '0;
        ex_row   = '0;
        ex_col   = '0;

        scen[0] = '{100, -1,  1'b0, 1'b1, 16, 1, 1'b0};
        scen[1] = '{ 50, -1,  1'b0, 1'b0, 16, 1, 1'b0};
        scen[2] = '{100, 100, 1'b1, 1'b0, 16, 1, 1'b1};
        scen[3] = '{ 50, -1,  1'b1, 1'b0, 16, 1, 1'b1};
        scen[4] = '{ 70, 0,   1'b0, 1'b0, 16, 1, 1'b1};

        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, '0, 1'b1);

        // s_valid while idle must not be consumed.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b1);

        for (int i = 0; i < 5; i++) runFrame(i, scen[i]);

        // Reset in the middle of a frame, then a clean frame.
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 40; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_0000 | DW'(i), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
        runFrame(5, scen[0]);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_2_channel_packer.md
Name: layer_2_channel_packer

Overview:
- Producer-side front end for the layer-2 feature-map blocks.
- Takes a serial stream of 32-bit IEEE-754 channel words (one word per beat, from the previous layer's output buffer or DMA) and packs each group of NUM_CH words into one pixel word of NUM_CH*DATA_WIDTH bits.
- Drives the packed word, with a one-cycle valid strobe, onto the data_in/valid_in bus shared by all layer-2 feature maps.
- Tracks pixel position and frame boundaries over an IMG_SIZE x IMG_SIZE frame.

Parameters:
- DATA_WIDTH, 32, width of one channel word (fp32).
- NUM_CH, 16, channels packed per pixel.
- IMG_SIZE, 208, frame width and height in pixels.
- CW, $clog2(IMG_SIZE), row/column counter width (derived, do not override).

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- start  in  1  begin one frame; sampled only in IDLE.
- s_data  in  DATA_WIDTH  channel word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final word of the frame.
- s_ready  out  1  packer accepts a word this cycle.
- m_data  out  NUM_CH*DATA_WIDTH  packed pixel; channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_valid  out  1  one-cycle strobe, m_data valid.
- m_row  out  CW  row of the pixel on m_data.
- m_col  out  CW  column of the pixel on m_data.
- busy  out  1  high while in PACK.
- frame_done  out  1  one-cycle pulse with the final pixel's m_valid.
- err_framing  out  1  sticky s_last mismatch flag.

Behaviour:
- Reset: state IDLE; ch_cnt, row, col = 0; m_data = 0; m_valid, frame_done, busy, s_ready, err_framing, m_row, m_col = 0. Reset mid-frame discards any partial pixel; nothing is emitted.
- States:
  - IDLE: s_ready = 0. If start = 1, go to PACK and clear err_framing and all counters.
  - PACK: s_ready = 1, busy = 1. A beat is accepted when s_valid & s_ready.
  - start is ignored in PACK.
- Accepted beat:
  - s_data is written into shadow lane ch_cnt.
  - ch_cnt increments; it wraps from NUM_CH-1 to 0.
- Beat with ch_cnt = NUM_CH-1:
  - Next cycle: m_data is loaded with the full shadow word including this beat; m_row/m_col = current row/col; m_valid = 1 for exactly one cycle.
  - Then col increments. At IMG_SIZE-1, col wraps to 0 and row increments.
  - Latency: 1 cycle from the 16th accepted beat to m_valid.
- Back-to-back beats are supported at 1 word/cycle, giving one m_valid every NUM_CH cycles.
- No downstream backpressure: the feature maps always accept. m_data holds its value until the next pixel.
- Final pixel (row = col = IMG_SIZE-1, ch_cnt = NUM_CH-1 accepted):
  - frame_done pulses with that pixel's m_valid.
  - State returns to IDLE on the same edge that raises m_valid, so s_ready = 0 from that cycle on.
- s_last checking:
  - Expected exactly on the final beat of the frame.
  - If s_last = 1 on any other accepted beat, or s_last = 0 on the final beat: err_framing = 1 (sticky until Rst or the next accepted start).
  - Counting continues unaffected; the frame length is always IMG_SIZE*IMG_SIZE*NUM_CH beats.
- s_valid = 0 gaps: all counters hold; no output.
- s_data/s_last outside an accepted beat are don't-care.

Test Plan:
- IMG_SIZE=4: Rst, start, 256 back-to-back beats with s_data = beat index and s_last on beat 255 -> 16 m_valid pulses spaced 16 cycles apart; pixel p has lane k = 16p+k; m_row/m_col scan (0,0)..(3,3); frame_done with pixel 15; err_framing = 0; s_ready = 0 afterwards.
- Random s_valid gaps (~50% duty) over the same frame -> identical m_data sequence; every m_valid arrives 1 cycle after the 16th accepted beat of its pixel.
- s_last asserted on beat 100 and absent on beat 255 -> err_framing = 1 from the cycle after beat 100; frame still completes with 16 pixels and frame_done; next start clears err_framing.
- Rst asserted after 40 beats, then start and a full frame -> no m_valid before the new frame's 16th beat; first pixel lanes come from the new data only; m_row = m_col = 0.
- start pulsed during PACK and s_valid driven in IDLE -> start has no effect; s_ready = 0 in IDLE and no beats are consumed.
